// File: rtl/dbg_bus_master.sv
// Byte-stream debug bridge: decodes write/read frames from an rx byte stream,
// runs one valid/ready bus cycle with arbitration and timeout, replies on tx.
module dbg_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  ACK_BYTE       = 8'hAA,
  parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rx_overrun
);

  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    CMD_WRITE  = 8'h01;
  localparam logic [7:0]    CMD_READ   = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_BUS,
    S_RESP
  } state_e;

  state_e        state_q;
  logic [1:0]    byte_cnt_q;
  logic          is_write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [TW-1:0] tout_q;
  logic [31:0]   rdata_q;
  logic          resp_read_q;
  logic [1:0]    tx_idx_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic          bus_req_q;
  logic          mem_valid_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_wstrb_q;
  logic          rx_overrun_q;

  logic       byte_last;
  logic       tx_accept;
  logic       tx_last;
  logic [1:0] tx_idx_d;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    byte_last = 1'b0;
    tx_accept = 1'b0;
    tx_last   = 1'b0;
    tx_idx_d  = tx_idx_q;
    byte_last = (byte_cnt_q == 2'd3);
    tx_accept = tx_valid_q && tx_ready;
    tx_last   = !resp_read_q || (tx_idx_q == 2'd3);
    tx_idx_d  = tx_idx_q + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: all state here is plain flops (no RAM), so everything is cleared
  // by the asynchronous reset and a mid-transaction reset leaves no trace.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tout_q       <= '0;
      rdata_q      <= '0;
      resp_read_q  <= 1'b0;
      tx_idx_q     <= 2'd0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      bus_req_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_valid && (state_q inside {S_REQ, S_BUS, S_RESP})) begin
        rx_overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt_q <= 2'd0;
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              is_write_q <= (rx_data == CMD_WRITE);
              state_q    <= S_ADDR;
            end else begin
              resp_read_q <= 1'b0;
              tx_idx_q    <= 2'd0;
              tx_data_q   <= NAK_BYTE;
              tx_valid_q  <= 1'b1;
              state_q     <= S_RESP;
            end
          end
        end

        // Address and data arrive LSB first, so shift in from the top.
        S_ADDR: begin
          if (rx_valid) begin
            addr_q     <= {rx_data, addr_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_last) begin
              byte_cnt_q <= 2'd0;
              if (is_write_q) begin
                state_q <= S_DATA;
              end else begin
                bus_req_q <= 1'b1;
                state_q   <= S_REQ;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            wdata_q    <= {rx_data, wdata_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_last) begin
              byte_cnt_q <= 2'd0;
              bus_req_q  <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (bus_gnt) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {addr_q[31:2], 2'b00};
            mem_wdata_q <= is_write_q ? wdata_q : 32'h0;
            mem_wstrb_q <= is_write_q ? 4'b1111 : 4'b0000;
            tout_q      <= TW'(1);
            state_q     <= S_BUS;
          end
        end

        // tout_q counts the cycles mem_valid has been high, this one included;
        // mem_ready is checked first so a completion on the last cycle wins.
        S_BUS: begin
          if (mem_ready) begin
            rdata_q     <= mem_rdata;
            mem_valid_q <= 1'b0;
            bus_req_q   <= 1'b0;
            resp_read_q <= !is_write_q;
            tx_idx_q    <= 2'd0;
            tx_data_q   <= is_write_q ? ACK_BYTE : mem_rdata[7:0];
            tx_valid_q  <= 1'b1;
            state_q     <= S_RESP;
          end else if (tout_q == TOUT_LIMIT) begin
            mem_valid_q <= 1'b0;
            bus_req_q   <= 1'b0;
            resp_read_q <= 1'b0;
            tx_idx_q    <= 2'd0;
            tx_data_q   <= NAK_BYTE;
            tx_valid_q  <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tout_q <= tout_q + TW'(1);
          end
        end

        S_RESP: begin
          if (tx_accept) begin
            if (tx_last) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              tx_idx_q  <= tx_idx_d;
              tx_data_q <= rdata_q[{tx_idx_d, 3'b000} +: 8];
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign bus_req    = bus_req_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: directed vector table, randomized frames against a
// rule-level model, and hand-written reset sequences.
module tb_dbg_bus_master;

  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rx_overrun;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;
  bit exp_ovr  = 1'b0;

  dbg_bus_master #(
    .TIMEOUT_CYCLES(TOUT),
    .ACK_BYTE      (8'hAA),
    .NAK_BYTE      (8'hEE)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_valid === 1'b1) valid_cnt++;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rdy_dly;   // -1: mem_ready never asserted
    logic [31:0] rdata;
    int          stall;     // tx_ready low cycles before each byte; -1 random
    bit          ovr;
    bit          gnt_drop;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    int          exp_len;
    logic [31:0] exp_tx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] wdata, input int gnt_dly, input int rdy_dly,
                              input logic [31:0] rdata, input int stall, input bit ovr,
                              input bit gnt_drop, input logic [31:0] exp_addr,
                              input logic [3:0] exp_wstrb, input int exp_len,
                              input logic [31:0] exp_tx);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.gnt_dly = gnt_dly;
    v.rdy_dly = rdy_dly; v.rdata = rdata; v.stall = stall; v.ovr = ovr;
    v.gnt_drop = gnt_drop; v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb;
    v.exp_len = exp_len; v.exp_tx = exp_tx;
    return v;
  endfunction

  // Reference model: what the frame should do, from the protocol rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit   completes = (v.rdy_dly >= 0) && (v.rdy_dly < TOUT);
    r.exp_addr  = v.addr & 32'hFFFF_FFFC;
    r.exp_wstrb = (v.cmd == 8'h01) ? 4'hF : 4'h0;
    if (v.cmd != 8'h01 && v.cmd != 8'h02) begin
      r.exp_len = 1; r.exp_tx = 32'hEE;
    end else if (!completes) begin
      r.exp_len = 1; r.exp_tx = 32'hEE;
    end else if (v.cmd == 8'h01) begin
      r.exp_len = 1; r.exp_tx = 32'hAA;
    end else begin
      r.exp_len = 4; r.exp_tx = v.rdata;
    end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [7:0] frame[$];
    bit         known;
    bit         write;
    bit         ok;
    int         k;
    int         exp_vc;
    int         n;
    int         budget;
    int         low;
    int         vc_start;
    bit         held_v;
    logic [7:0] held;

    known = (v.cmd == 8'h01) || (v.cmd == 8'h02);
    write = (v.cmd == 8'h01);
    frame.push_back(v.cmd);
    if (known) for (int i = 0; i < 4; i++) frame.push_back(v.addr[8*i +: 8]);
    if (write) for (int i = 0; i < 4; i++) frame.push_back(v.wdata[8*i +: 8]);
    vc_start = valid_cnt;
    foreach (frame[i]) send_byte(frame[i]);

    if (known) begin
      check({tag, "_bus_req_in_req"}, bus_req, 1'b1);
      ok = 1'b1;
      for (int i = 0; i < v.gnt_dly; i++) begin
        @(negedge clk);
        if (mem_valid !== 1'b0 || bus_req !== 1'b1) ok = 1'b0;
        rx_valid  = v.ovr && (i == 2);
        rx_data   = 8'h5A;
        mem_ready = 1'($urandom_range(0, 1));
      end
      rx_valid = 1'b0;
      if (v.gnt_dly > 0) check({tag, "_idle_without_gnt"}, ok, 1'b1);
      if (v.ovr && v.gnt_dly >= 4) exp_ovr = 1'b1;

      bus_gnt   = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      check({tag, "_valid_after_gnt"}, mem_valid, 1'b1);
      check({tag, "_addr"}, mem_addr, v.exp_addr);
      check({tag, "_wstrb"}, mem_wstrb, v.exp_wstrb);
      if (write) check({tag, "_wdata"}, mem_wdata, v.wdata);
      if (v.gnt_drop) bus_gnt = 1'b0;

      k  = 0;
      ok = 1'b1;
      while (mem_valid === 1'b1 && k < 100) begin
        if (mem_addr !== v.exp_addr || mem_wstrb !== v.exp_wstrb || bus_req !== 1'b1 ||
            (write && mem_wdata !== v.wdata)) ok = 1'b0;
        mem_ready = (k == v.rdy_dly);
        mem_rdata = mem_ready ? v.rdata : $urandom();
        @(negedge clk);
        k++;
      end
      mem_ready = 1'b0;
      bus_gnt   = 1'b0;
      exp_vc = (v.rdy_dly >= 0 && v.rdy_dly < TOUT) ? v.rdy_dly + 1 : TOUT;
      check({tag, "_valid_cycles"}, k, exp_vc);
      check({tag, "_bus_stable"}, ok, 1'b1);
      check({tag, "_bus_req_drop"}, bus_req, 1'b0);
    end else begin
      check({tag, "_no_bus_activity"}, valid_cnt - vc_start, 0);
    end

    n = 0; budget = 0; low = 0; held_v = 1'b0; held = '0; ok = 1'b1;
    while (n < v.exp_len && budget < 400) begin
      if (tx_valid === 1'b1) begin
        if (held_v && tx_data !== held) ok = 1'b0;
        tx_ready = (v.stall >= 0) ? (low >= v.stall) : 1'($urandom_range(0, 1));
        if (tx_ready) begin
          check($sformatf("%s_tx%0d", tag, n), tx_data, v.exp_tx[8*n +: 8]);
          n++; low = 0; held_v = 1'b0;
        end else begin
          low++; held = tx_data; held_v = 1'b1;
        end
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      budget++;
    end
    tx_ready = 1'b0;
    check({tag, "_tx_count"}, n, v.exp_len);
    check({tag, "_tx_hold"}, ok, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (tx_valid !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check({tag, "_tx_idle_after"}, ok, 1'b1);
    check({tag, "_rx_overrun"}, rx_overrun, exp_ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_valid"}, mem_valid, 1'b0);
    check({tag, "_bus_req"}, bus_req, 1'b0);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_rx_overrun"}, rx_overrun, 1'b0);
    check({tag, "_wstrb"}, mem_wstrb, 4'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_tx_data"}, tx_data, 8'h0);
  endtask

  initial begin
    vec_t dir[$];
    vec_t v;
    int   r;
    int   k;

    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    bus_gnt = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    resetn = 1'b1;
    @(negedge clk);

    dir.push_back(mk(8'h01, 32'h1200_0000, 32'hDEAD_BEEF, 0, 3, 32'h0, 0, 0, 0,
                     32'h1200_0000, 4'hF, 1, 32'hAA));
    dir.push_back(mk(8'h02, 32'h2010_0028, 32'h0, 0, 1, 32'h0000_0513, 0, 0, 0,
                     32'h2010_0028, 4'h0, 4, 32'h0000_0513));
    dir.push_back(mk(8'h02, 32'h0000_0104, 32'h0, 2, -1, 32'h0, 0, 0, 0,
                     32'h0000_0104, 4'h0, 1, 32'hEE));
    dir.push_back(mk(8'h02, 32'h0000_0040, 32'h0, 10, 0, 32'hCAFE_F00D, 0, 1, 0,
                     32'h0000_0040, 4'h0, 4, 32'hCAFE_F00D));
    dir.push_back(mk(8'h02, 32'h8000_0003, 32'h0, 1, 2, 32'h1122_3344, 5, 0, 0,
                     32'h8000_0000, 4'h0, 4, 32'h1122_3344));
    dir.push_back(mk(8'h7F, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0,
                     32'h0, 4'h0, 1, 32'hEE));
    dir.push_back(mk(8'h02, 32'h0000_0ACC, 32'h0, 0, 15, 32'hA5A5_5A5A, 0, 0, 0,
                     32'h0000_0ACC, 4'h0, 4, 32'hA5A5_5A5A));
    dir.push_back(mk(8'h01, 32'h0000_1001, 32'h0123_4567, 0, 16, 32'h0, 1, 0, 0,
                     32'h0000_1000, 4'hF, 1, 32'hEE));
    dir.push_back(mk(8'h01, 32'h4000_000E, 32'h89AB_CDEF, 3, 4, 32'h0, 2, 0, 1,
                     32'h4000_000C, 4'hF, 1, 32'hAA));
    dir.push_back(mk(8'h03, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0,
                     32'h0, 4'h0, 1, 32'hEE));

    foreach (dir[i]) run_txn(dir[i], $sformatf("dir%0d", i));

    // Reset while a read sits in BUS: outputs clear at once, no response.
    v = mk(8'h02, 32'h0000_0055, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 0, 32'h0);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
    bus_gnt = 1'b1;
    @(negedge clk);
    check("rst_bus_valid_before", mem_valid, 1'b1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("rst_bus");
    bus_gnt = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || mem_valid !== 1'b0) k++;
    end
    check("rst_bus_no_response", k, 0);
    run_txn(mk(8'h01, 32'h0000_2000, 32'h5555_AAAA, 0, 0, 32'h0, 0, 0, 0,
               32'h0000_2000, 4'hF, 1, 32'hAA), "post_rst");

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) v.cmd = 8'h01;
      else if (r < 8) v.cmd = 8'h02;
      else begin
        v.cmd = 8'($urandom());
        while (v.cmd == 8'h01 || v.cmd == 8'h02) v.cmd = 8'($urandom());
      end
      v.addr     = $urandom();
      v.wdata    = $urandom();
      v.gnt_dly  = $urandom_range(0, 6);
      v.rdy_dly  = int'($urandom_range(0, 20)) - 1;
      v.rdata    = $urandom();
      v.stall    = -1;
      v.ovr      = (v.gnt_dly >= 4) && ($urandom_range(0, 1) == 1);
      v.gnt_drop = ($urandom_range(0, 1) == 1);
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
